// File: rtl/vga_wave_display_if.sv
// Capture-RAM read port seen by the VGA waveform renderer.
// Handshake: no valid/ready; rd_addr is presented every cycle and sample_data answers it exactly one cycle later, with no stalls.
interface vga_wave_display_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10
);
  logic              write_finish;
  logic [NUM_CH-1:0] sample_data;
  logic [ADDR_W-1:0] rd_addr;

  modport master (
    input  write_finish,
    input  sample_data,
    output rd_addr
  );

  modport slave (
    output write_finish,
    output sample_data,
    input  rd_addr
  );
endinterface

// File: rtl/vga_wave_display.sv
// VGA timing plus stacked logic-analyzer lanes with horizontal grid, 2-stage pixel pipeline.
// Optional macro VGA_VGRID_EN adds vertical time-division grid lines every VGRID_PITCH pixels.
module vga_wave_display #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BP        = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 29,
  parameter int NUM_CH      = 4,
  parameter int HI_OFF      = 12,
  parameter int LO_OFF      = 170,
  parameter int ADDR_W      = 10,
  parameter int VGRID_PITCH = 128
) (
  input  logic                clk65,
  input  logic                reset,
  vga_wave_display_if.master  cap,
  output logic [2:0]          RGBpin,
  output logic                H_sync_pin,
  output logic                V_sync_pin,
  output logic [10:0]         pixel_number,
  output logic [9:0]          line_number,
  output logic                frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LANE_H  = V_ACTIVE / NUM_CH;
  localparam int LANE_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  ROW_LAST = 10'(LANE_H - 1);
  localparam logic [9:0]  ROW_HI   = 10'(HI_OFF);
  localparam logic [9:0]  ROW_LO   = 10'(LO_OFF);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_CH - 1);

  localparam bit CFG_OK = (NUM_CH >= 1) && (NUM_CH <= 8) && (HI_OFF < LO_OFF) &&
                          (LO_OFF < LANE_H) && ((1 << ADDR_W) >= H_ACTIVE) &&
                          (VGRID_PITCH > 0) && (H_TOTAL <= 2048) && (V_TOTAL <= 1024);
  if (!CFG_OK) begin : g_bad_cfg
    $error("vga_wave_display: inconsistent parameter set");
  end

  // Stage 0: counters
  logic [10:0]       h_cnt;
  logic [9:0]        v_cnt;
  logic [LANE_W-1:0] lane_cnt;
  logic [9:0]        row_cnt;
  logic              h_last;
  logic              v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Lane/row track v incrementally; lane saturates so blanking lines never index past NUM_CH-1.
  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      lane_cnt <= '0;
      row_cnt  <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt    <= '0;
        lane_cnt <= '0;
        row_cnt  <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
        if (row_cnt == ROW_LAST) begin
          row_cnt <= '0;
          if (lane_cnt != LANE_LAST) lane_cnt <= lane_cnt + 1'b1;
        end else begin
          row_cnt <= row_cnt + 10'd1;
        end
      end
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  logic vgrid0;
`ifdef VGA_VGRID_EN
  localparam logic [10:0] VG_LAST = 11'(VGRID_PITCH - 1);
  logic [10:0] vg_cnt;

  always_ff @(posedge clk65 or posedge reset) begin
    if (reset)                 vg_cnt <= '0;
    else if (h_last)           vg_cnt <= '0;
    else if (vg_cnt == VG_LAST) vg_cnt <= '0;
    else                       vg_cnt <= vg_cnt + 11'd1;
  end

  assign vgrid0 = (vg_cnt == 11'd0) && (h_cnt != 11'd0);
`else
  assign vgrid0 = 1'b0;
`endif

  logic active0;
  logic hs0;
  logic vs0;
  logic red0;

  assign active0      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0          = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs0          = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign red0         = active0 && (((row_cnt == 10'd0) && (lane_cnt != '0)) || vgrid0);
  assign cap.rd_addr  = (h_cnt < H_ACT) ? ADDR_W'(h_cnt) : '0;
  assign pixel_number = h_cnt;
  assign line_number  = v_cnt;
  // Gated by reset so the held-at-zero counters do not fake a frame start while in reset.
  assign frame_start  = (h_cnt == 11'd0) && (v_cnt == 10'd0) && !reset;

  // Stage 1: align counter-derived state with the RAM read data
  logic              s1_active;
  logic              s1_hs;
  logic              s1_vs;
  logic              s1_red;
  logic              s1_first;
  logic [LANE_W-1:0] s1_lane;
  logic [9:0]        s1_row;
  logic [NUM_CH-1:0] prev_data;
  logic              frame_valid;

  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      s1_active   <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_red      <= 1'b0;
      s1_first    <= 1'b0;
      s1_lane     <= '0;
      s1_row      <= '0;
      prev_data   <= '0;
      frame_valid <= 1'b0;
    end else begin
      s1_active <= active0;
      s1_hs     <= hs0;
      s1_vs     <= vs0;
      s1_red    <= red0;
      s1_first  <= (h_cnt == 11'd0);
      s1_lane   <= lane_cnt;
      s1_row    <= row_cnt;
      prev_data <= cap.sample_data;
      if (frame_start) frame_valid <= cap.write_finish;
    end
  end

  logic cur_bit;
  logic prev_bit;
  logic level_px;
  logic edge_px;
  logic trace_px;

  assign cur_bit  = cap.sample_data[s1_lane];
  assign prev_bit = s1_first ? cur_bit : prev_data[s1_lane];
  assign level_px = cur_bit ? (s1_row == ROW_HI) : (s1_row == ROW_LO);
  assign edge_px  = (cur_bit != prev_bit) && (s1_row >= ROW_HI) && (s1_row <= ROW_LO);
  assign trace_px = s1_active && frame_valid && (level_px || edge_px);

  // Stage 2: registered pins
  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      RGBpin     <= 3'b000;
      H_sync_pin <= 1'b1;
      V_sync_pin <= 1'b1;
    end else begin
      RGBpin     <= {trace_px, trace_px, s1_red};
      H_sync_pin <= ~s1_hs;
      V_sync_pin <= ~s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_wave_display.sv
// Bench for vga_wave_display on a reduced raster; pins are predicted from absolute pixel index arithmetic.
module tb_vga_wave_display;

  localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 16, VFP = 1, VSW = 2, VBP = 2;
  localparam int NC = 4, HI = 1, LO = 3, AW = 5, VP = 8;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int LANE_H = VA / NC;

  logic        clk65 = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  RGBpin;
  logic        H_sync_pin;
  logic        V_sync_pin;
  logic [10:0] pixel_number;
  logic [9:0]  line_number;
  logic        frame_start;

  vga_wave_display_if #(.NUM_CH(NC), .ADDR_W(AW)) cap ();

  vga_wave_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .NUM_CH(NC), .HI_OFF(HI), .LO_OFF(LO), .ADDR_W(AW), .VGRID_PITCH(VP)
  ) dut (
    .clk65(clk65),
    .reset(reset),
    .cap(cap),
    .RGBpin(RGBpin),
    .H_sync_pin(H_sync_pin),
    .V_sync_pin(V_sync_pin),
    .pixel_number(pixel_number),
    .line_number(line_number),
    .frame_start(frame_start)
  );

  // clock / reset
  always #5 clk65 = ~clk65;

  // behavioural capture RAM, 1-cycle read latency
  logic [NC-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk65) cap.sample_data <= mem[cap.rd_addr];

  int n;
  int checks;
  int fails;
  bit fv_arr [0:63];

  // reference model: everything derived from absolute pixel index p since reset release
  function automatic int exp_rgb(int p);
    int h, v, f, lane, row;
    logic [NC-1:0] w_cur, w_prev;
    logic cur, prev, red, tr;
    if (p < 0) return 0;
    h = p % HT;
    v = (p / HT) % VT;
    f = (p / FRAME) % 64;
    if (!(h < HA && v < VA)) return 0;
    lane = v / LANE_H;
    row  = v % LANE_H;
    red  = (row == 0) && (lane > 0);
`ifdef VGA_VGRID_EN
    if (h != 0 && (h % VP) == 0) red = 1'b1;
`endif
    w_cur = mem[h];
    cur   = w_cur[lane];
    if (h == 0) prev = cur;
    else begin
      w_prev = mem[h-1];
      prev   = w_prev[lane];
    end
    tr = fv_arr[f] && ((cur && row == HI) || (!cur && row == LO) ||
                       (cur != prev && row >= HI && row <= LO));
    return {29'd0, tr, tr, red};
  endfunction

  function automatic int exp_hs(int p);
    int h;
    if (p < 0) return 1;
    h = p % HT;
    return (h >= HA + HFP && h < HA + HFP + HSW) ? 0 : 1;
  endfunction

  function automatic int exp_vs(int p);
    int v;
    if (p < 0) return 1;
    v = (p / HT) % VT;
    return (v >= VA + VFP && v < VA + VFP + VSW) ? 0 : 1;
  endfunction

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int h, v, p;
    h = n % HT;
    v = (n / HT) % VT;
    p = n - 2;
    check("rgb",          RGBpin,       exp_rgb(p));
    check("hsync",        H_sync_pin,   exp_hs(p));
    check("vsync",        V_sync_pin,   exp_vs(p));
    check("pixel_number", pixel_number, h);
    check("line_number",  line_number,  v);
    check("frame_start",  frame_start,  (h == 0 && v == 0) ? 1 : 0);
    check("rd_addr",      cap.rd_addr,  (h < HA) ? h : 0);
  endtask

  task automatic check_reset_values();
    check("rst_rgb",    RGBpin,       0);
    check("rst_hsync",  H_sync_pin,   1);
    check("rst_vsync",  V_sync_pin,   1);
    check("rst_pixel",  pixel_number, 0);
    check("rst_line",   line_number,  0);
    check("rst_fstart", frame_start,  0);
    check("rst_rdaddr", cap.rd_addr,  0);
  endtask

  // driver tasks
  task automatic step();
    if (n % FRAME == 0) fv_arr[(n / FRAME) % 64] = cap.write_finish;
    @(posedge clk65);
    n++;
    @(negedge clk65);
    check_cycle();
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic goto_pos(input int line, input int col);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (n % FRAME == line * HT + col) break;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) mem[i] = NC'($urandom);
  endtask

  task automatic release_reset();
    @(negedge clk65);
    reset = 1'b0;
    n = 0;
    #1;
    check_cycle();
  endtask

  initial begin
    n = 0;
    checks = 0;
    fails = 0;
    cap.write_finish = 1'b1;
    cap.sample_data  = '0;
    fill_random();

    // reset state
    repeat (3) @(negedge clk65);
    check_reset_values();
    release_reset();

    // random data, capture valid
    run(FRAME + 50);

    // constant 0101 pattern: flat levels, no edge strokes
    goto_pos(VA, 0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = 4'b0101;
    run(FRAME);

    // channel 0 toggles 0 -> 1 at column 12
    goto_pos(VA, 0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = {3'($urandom), (i >= 12) ? 1'b1 : 1'b0};
    run(FRAME);

    // drop write_finish mid-frame: this frame keeps traces, next is grid only
    goto_pos(VA, 0);
    fill_random();
    goto_pos(8, 0);
    cap.write_finish = 1'b0;
    run(FRAME + HT);
    cap.write_finish = 1'b1;
    run(FRAME);

    // reset mid-line
    goto_pos(5, 20);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk65);
    @(posedge clk65);
    release_reset();
    run(FRAME);

    // random frames with write_finish flipping at random lines
    for (int f = 0; f < 2; f++) begin
      goto_pos(VA, 0);
      fill_random();
      goto_pos($urandom_range(VA - 1, 0), $urandom_range(HT - 1, 0));
      cap.write_finish = 1'($urandom);
    end
    run(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
